// File: rtl/apple1_pkg.sv
// ----------------------------------------------------------------------------
// apple1_pkg
//   Definitions shared by the Apple-1 keyboard/display PIA:
//   - PIA register offsets (0xD010-0xD013 relative to the PIA base)
//   - ASCII bounds used for lower-to-upper case folding
//   - display latch state type
//   - kbd_fold(): turns a raw key code into the 7-bit code kept in the FIFO
// ----------------------------------------------------------------------------
package apple1_pkg;

    localparam logic [1:0] PIA_KBD   = 2'd0;
    localparam logic [1:0] PIA_KBDCR = 2'd1;
    localparam logic [1:0] PIA_DSP   = 2'd2;
    localparam logic [1:0] PIA_DSPCR = 2'd3;

    localparam logic [7:0] ASCII_LC_A     = 8'h61;
    localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    // The display side is a one-deep latch: IDLE means no character pending.
    typedef enum logic {
        DSP_IDLE = 1'b0,
        DSP_BUSY = 1'b1
    } dsp_state_e;

    // Bit 7 of the incoming code is dropped before the range test, so a key
    // arriving with its high bit set is folded exactly like its 7-bit value.
    function automatic logic [6:0] kbd_fold(input logic [7:0] code,
                                            input bit         force_upper);
        logic [7:0] c7;
        c7 = {1'b0, code[6:0]};
        if (force_upper && (c7 >= ASCII_LC_A) && (c7 <= ASCII_LC_Z))
            c7 = c7 - ASCII_CASE_BIT;
        return c7[6:0];
    endfunction

endpackage

// File: rtl/apple1_pia_if.sv
// ----------------------------------------------------------------------------
// apple1_pia_if
//   6502-side register bus of the PIA.
//     enable  : access strobe (chip select & cpu_clken)
//     address : register select (KBD, KBDCR, DSP, DSPCR)
//     w_en    : 1 = write access
//     din     : CPU write data
//     dout    : registered CPU read data
//   master = CPU side, slave = PIA side.
// ----------------------------------------------------------------------------
interface apple1_pia_if;
    logic       enable;
    logic [1:0] address;
    logic       w_en;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output enable, address, w_en, din, input  dout);
    modport slave  (input  enable, address, w_en, din, output dout);
endinterface

// File: rtl/pia_kbd_fifo.sv
// ----------------------------------------------------------------------------
// pia_kbd_fifo
//   Synchronous FIFO holding keyboard codes until the CPU reads KBD.
//     clk25 : clock, posedge
//     reset : synchronous, active-high; empties the FIFO
//     push  : write din (ignored while full)
//     din   : code to store
//     pop   : drop head (ignored while empty)
//     dout  : current head, combinational from storage
//     empty : no entries
//     full  : DEPTH entries
//   DEPTH must be a power of two >= 2; pointers wrap naturally.
// ----------------------------------------------------------------------------
module pia_kbd_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk25,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    // count never exceeds DEPTH = 2**AW, so its MSB alone flags full.
    assign empty   = (count_q == '0);
    assign full    = count_q[AW];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk25) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers decide what
    // is valid, and a reset-free array maps onto plain RAM/flops cheaply.
    always_ff @(posedge clk25) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/apple1_pia.sv
// ----------------------------------------------------------------------------
// apple1_pia
//   Apple-1 keyboard/display PIA (KBD, KBDCR, DSP, DSPCR as polled by WozMon).
//     clk25     : clock, posedge
//     reset     : synchronous, active-high, overrides everything
//     bus       : CPU register bus (apple1_pia_if.slave)
//     kbd_data  : incoming key code        kbd_valid : key present
//     kbd_ready : FIFO can accept (~full)
//     dsp_data  : character to display     dsp_valid : character pending
//     dsp_ready : display sink accepts
//   Reads are registered: dout follows address one cycle later, whether or
//   not enable is set. Only an enabled KBD read pops the keyboard FIFO.
// ----------------------------------------------------------------------------
module apple1_pia
    import apple1_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter bit FORCE_UPPER = 1'b1
) (
    input  logic              clk25,
    input  logic              reset,
    apple1_pia_if.slave       bus,
    input  logic [7:0]        kbd_data,
    input  logic              kbd_valid,
    output logic              kbd_ready,
    output logic [6:0]        dsp_data,
    output logic              dsp_valid,
    input  logic              dsp_ready
);

    logic       cpu_rd, cpu_wr;
    logic       kbd_push, kbd_pop;
    logic [6:0] fifo_head;
    logic       fifo_empty, fifo_full;

    dsp_state_e dsp_state_q, dsp_state_d;
    logic [6:0] dsp_data_q,  dsp_data_d;
    logic [6:0] kbdcr_q,     kbdcr_d;
    logic [7:0] dspcr_q,     dspcr_d;
    logic [7:0] dout_q,      dout_d;

    assign cpu_rd    = bus.enable & ~bus.w_en;
    assign cpu_wr    = bus.enable &  bus.w_en;
    assign kbd_ready = ~fifo_full;
    assign kbd_push  = kbd_valid & kbd_ready;
    assign kbd_pop   = cpu_rd & (bus.address == PIA_KBD);

    assign dsp_valid = (dsp_state_q == DSP_BUSY);
    assign dsp_data  = dsp_data_q;
    assign bus.dout  = dout_q;

    pia_kbd_fifo #(
        .WIDTH (7),
        .DEPTH (FIFO_DEPTH)
    ) u_kbd_fifo (
        .clk25 (clk25),
        .reset (reset),
        .push  (kbd_push),
        .din   (kbd_fold(kbd_data, FORCE_UPPER)),
        .pop   (kbd_pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        dsp_state_d = dsp_state_q;
        dsp_data_d  = dsp_data_q;
        kbdcr_d     = kbdcr_q;
        dspcr_d     = dspcr_q;
        dout_d      = dout_q;

        if (cpu_wr && bus.address == PIA_KBDCR) kbdcr_d = bus.din[6:0];
        if (cpu_wr && bus.address == PIA_DSPCR) dspcr_d = bus.din;

        // The write decision looks at the registered state, so a DSP write in
        // the same cycle the sink accepts is still dropped.
        case (dsp_state_q)
            DSP_IDLE: if (cpu_wr && bus.address == PIA_DSP) begin
                dsp_data_d  = bus.din[6:0];
                dsp_state_d = DSP_BUSY;
            end
            DSP_BUSY: if (dsp_ready) dsp_state_d = DSP_IDLE;
            default:  dsp_state_d = DSP_IDLE;
        endcase

        case (bus.address)
            PIA_KBD:   dout_d = fifo_empty ? 8'h80 : {1'b1, fifo_head};
            PIA_KBDCR: dout_d = {~fifo_empty, kbdcr_q};
            PIA_DSP:   dout_d = {dsp_valid, dsp_data_q};
            default:   dout_d = dspcr_q;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            dsp_state_q <= DSP_IDLE;
            dsp_data_q  <= '0;
            kbdcr_q     <= '0;
            dspcr_q     <= '0;
            dout_q      <= '0;
        end else begin
            dsp_state_q <= dsp_state_d;
            dsp_data_q  <= dsp_data_d;
            kbdcr_q     <= kbdcr_d;
            dspcr_q     <= dspcr_d;
            dout_q      <= dout_d;
        end
    end

endmodule

// File: tb/tb_apple1_pia.sv
// ----------------------------------------------------------------------------
// tb_apple1_pia
//   Directed self-checking bench for apple1_pia (FIFO_DEPTH=4, FORCE_UPPER=1).
//   Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_apple1_pia;
    import apple1_pkg::*;

    logic       clk25 = 1'b0;
    logic       reset;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       kbd_ready;
    logic [6:0] dsp_data;
    logic       dsp_valid;
    logic       dsp_ready;

    int n_checks = 0;
    int n_errors = 0;

    apple1_pia_if bus ();

    apple1_pia #(
        .FIFO_DEPTH  (4),
        .FORCE_UPPER (1'b1)
    ) dut (
        .clk25     (clk25),
        .reset     (reset),
        .bus       (bus),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready),
        .dsp_data  (dsp_data),
        .dsp_valid (dsp_valid),
        .dsp_ready (dsp_ready)
    );

    always #20 clk25 = ~clk25;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    // Enabled read: dout captures the register at the edge; KBD pops.
    task automatic cpu_read(input logic [1:0] addr, output logic [7:0] data);
        bus.enable  = 1'b1;
        bus.w_en    = 1'b0;
        bus.address = addr;
        tick();
        data        = bus.dout;
        bus.enable  = 1'b0;
    endtask

    // Non-enabled read: dout still follows address, no side effect.
    task automatic cpu_peek(input logic [1:0] addr, output logic [7:0] data);
        bus.enable  = 1'b0;
        bus.w_en    = 1'b0;
        bus.address = addr;
        tick();
        data        = bus.dout;
    endtask

    task automatic cpu_write(input logic [1:0] addr, input logic [7:0] data);
        bus.enable  = 1'b1;
        bus.w_en    = 1'b1;
        bus.address = addr;
        bus.din     = data;
        tick();
        bus.enable  = 1'b0;
        bus.w_en    = 1'b0;
    endtask

    task automatic push_key(input logic [7:0] code);
        check("push_ready", {7'd0, kbd_ready}, 8'h01);
        kbd_data  = code;
        kbd_valid = 1'b1;
        tick();
        kbd_valid = 1'b0;
    endtask

    logic [7:0] rd;
    logic [7:0] keys   [5] = '{8'h48, 8'h45, 8'h4C, 8'h50, 8'h21};
    logic [7:0] fold_in [5] = '{8'hE2, 8'h7B, 8'h60, 8'h7A, 8'h41};
    logic [7:0] fold_exp[5] = '{8'hC2, 8'hFB, 8'hE0, 8'hDA, 8'hC1};

    initial begin
        reset       = 1'b1;
        kbd_data    = 8'h00;
        kbd_valid   = 1'b0;
        dsp_ready   = 1'b0;
        bus.enable  = 1'b0;
        bus.w_en    = 1'b0;
        bus.address = PIA_KBD;
        bus.din     = 8'h00;

        // Power-on reset.
        repeat (3) tick();
        check("rst_dout",      bus.dout,             8'h00);
        check("rst_dsp_valid", {7'd0, dsp_valid},    8'h00);
        check("rst_dsp_data",  {1'b0, dsp_data},     8'h00);
        check("rst_kbd_ready", {7'd0, kbd_ready},    8'h01);
        reset = 1'b0;

        // 1. Reset while a character is pending and two keys are queued.
        cpu_write(PIA_DSP, 8'h41);
        check("t1_dsp_valid_set", {7'd0, dsp_valid}, 8'h01);
        push_key(8'h31);
        push_key(8'h32);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t1_dsp_valid", {7'd0, dsp_valid}, 8'h00);
        check("t1_dsp_data",  {1'b0, dsp_data},  8'h00);
        check("t1_kbd_ready", {7'd0, kbd_ready}, 8'h01);
        check("t1_dout",      bus.dout,          8'h00);
        cpu_read(PIA_KBDCR, rd); check("t1_kbdcr", rd, 8'h00);
        cpu_read(PIA_KBD,   rd); check("t1_kbd",   rd, 8'h80);

        // 2. Lower-case key is folded; KBD read pops it.
        push_key(8'h61);
        cpu_read(PIA_KBDCR, rd); check("t2_kbdcr_full",  rd, 8'h80);
        cpu_read(PIA_KBD,   rd); check("t2_kbd",         rd, 8'hC1);
        cpu_read(PIA_KBDCR, rd); check("t2_kbdcr_empty", rd, 8'h00);
        for (int i = 0; i < 5; i++) begin
            push_key(fold_in[i]);
            cpu_read(PIA_KBD, rd);
            check($sformatf("t2_fold%0d", i), rd, fold_exp[i]);
        end

        // 3. Five keys into a 4-deep FIFO with kbd_valid held.
        for (int i = 0; i < 4; i++) begin
            kbd_data  = keys[i];
            kbd_valid = 1'b1;
            tick();
        end
        check("t3_full_ready", {7'd0, kbd_ready}, 8'h00);
        kbd_data = keys[4];
        repeat (2) tick();
        check("t3_still_full", {7'd0, kbd_ready}, 8'h00);
        cpu_read(PIA_KBD, rd);  // refused push this edge: FIFO was full
        check("t3_kbd0", rd, {1'b1, keys[0][6:0]});
        check("t3_room", {7'd0, kbd_ready}, 8'h01);
        tick();                 // fifth key now accepted
        kbd_valid = 1'b0;
        check("t3_refull", {7'd0, kbd_ready}, 8'h00);
        for (int i = 1; i < 5; i++) begin
            cpu_read(PIA_KBD, rd);
            check($sformatf("t3_kbd%0d", i), rd, {1'b1, keys[i][6:0]});
        end
        cpu_read(PIA_KBDCR, rd); check("t3_empty", rd, 8'h00);

        // 4. Display latch: busy drops writes, acceptance clears valid.
        dsp_ready = 1'b0;
        cpu_write(PIA_DSP, 8'hC8);
        check("t4_valid",  {7'd0, dsp_valid}, 8'h01);
        check("t4_data",   {1'b0, dsp_data},  8'h48);
        cpu_read(PIA_DSP, rd); check("t4_dsp_busy", rd, 8'hC8);
        cpu_write(PIA_DSP, 8'h49);
        check("t4_drop",   {1'b0, dsp_data},  8'h48);
        dsp_ready = 1'b1;
        tick();
        dsp_ready = 1'b0;
        check("t4_accept", {7'd0, dsp_valid}, 8'h00);
        cpu_read(PIA_DSP, rd); check("t4_dsp_idle", rd, 8'h48);
        cpu_write(PIA_DSP, 8'h41);
        dsp_ready = 1'b1;
        cpu_write(PIA_DSP, 8'h55);  // same cycle as acceptance: dropped
        dsp_ready = 1'b0;
        check("t4_same_valid", {7'd0, dsp_valid}, 8'h00);
        check("t4_same_data",  {1'b0, dsp_data},  8'h41);

        // 5. Simultaneous push and pop at count 2; peek does not pop.
        push_key(8'h41);
        push_key(8'h42);
        kbd_data  = 8'h43;
        kbd_valid = 1'b1;
        cpu_read(PIA_KBD, rd);
        kbd_valid = 1'b0;
        check("t5_pushpop", rd, 8'hC1);
        check("t5_ready",   {7'd0, kbd_ready}, 8'h01);
        cpu_peek(PIA_KBD, rd); check("t5_peek1", rd, 8'hC2);
        cpu_peek(PIA_KBD, rd); check("t5_peek2", rd, 8'hC2);
        cpu_read(PIA_KBD, rd); check("t5_kbd_b", rd, 8'hC2);
        cpu_read(PIA_KBD, rd); check("t5_kbd_c", rd, 8'hC3);
        cpu_read(PIA_KBDCR, rd); check("t5_empty", rd, 8'h00);

        // 6. Control registers; KBD writes ignored.
        cpu_write(PIA_DSPCR, 8'h5A);
        cpu_write(PIA_KBDCR, 8'h27);
        cpu_read(PIA_DSPCR, rd); check("t6_dspcr",       rd, 8'h5A);
        cpu_read(PIA_KBDCR, rd); check("t6_kbdcr_empty", rd, 8'h27);
        push_key(8'h33);
        cpu_read(PIA_KBDCR, rd); check("t6_kbdcr_key",   rd, 8'hA7);
        cpu_write(PIA_KBD, 8'hFF);
        cpu_read(PIA_KBD, rd);   check("t6_kbd_wr_ign",  rd, 8'hB3);
        cpu_read(PIA_KBDCR, rd); check("t6_kbdcr_after", rd, 8'h27);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
